instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Writer side of the Instruction_Memory write port. Receives a byte stream from the debug/UART path over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written to consecutive instruction memory addresses starting at 0. Loading terminates on the HALT word or when memory is full, then the loader reports done to the debug unit.

Parameters:
ADDR_W, 5, instruction memory address width; depth = 2**ADDR_W words
DATA_W, 32, instruction word width; fixed at 4 bytes
HALT_WORD, 32'hFFFFFFFF, instruction encoding that ends a load (is itself written)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
i_start  in  1  begin a new load (1-cycle pulse)
i_byte  in  8  incoming program byte
i_byte_valid  in  1  i_byte is valid this cycle
o_byte_ready  out  1  loader accepts a byte this cycle
o_addr  out  ADDR_W  instruction memory write address (to i_addr)
o_data  out  DATA_W  assembled word (to i_data)
o_wr_en  out  1  write strobe (to i_wr_en), 1-cycle pulse per word
o_busy  out  1  high in RECV and WRITE
o_done  out  1  load complete, held until next i_start or rst
o_word_count  out  ADDR_W+1  words written in current/last load

Behaviour:
- Reset (rst=1 at posedge): state IDLE; o_addr=0, o_data=0, o_wr_en=0, o_byte_ready=0, o_busy=0, o_done=0, o_word_count=0, byte index=0. Reset mid-load discards any partial word; no write is issued.
- States: IDLE, RECV, WRITE, DONE.
- IDLE/DONE: i_start=1 -> RECV; o_addr=0, o_word_count=0, byte index=0, o_done=0 (same edge). Bytes presented while not in RECV are not accepted (o_byte_ready=0).
- RECV: o_byte_ready=1 (registered, high for every RECV cycle). Byte accepted when i_byte_valid && o_byte_ready at posedge.
  - Byte index 0..3: byte 0 -> o_data[31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - On acceptance of byte 3 -> WRITE; index wraps to 0.
  - Gaps (i_byte_valid=0) stall indefinitely; no timeout.
- WRITE (exactly 1 cycle): o_wr_en=1, o_byte_ready=0, o_addr/o_data stable. On leaving:
  - o_word_count += 1.
  - If o_data==HALT_WORD or o_addr==2**ADDR_W-1 -> DONE, o_addr holds.
  - Else o_addr += 1 -> RECV.
- Latency: o_wr_en asserts the cycle after the 4th byte is accepted; minimum 5 cycles per word.
- o_data changes only on byte acceptance; o_addr only on start/reset/WRITE exit, so the memory sees stable address/data with wr_en.
- i_start in RECV or WRITE is ignored (no restart mid-load).
- Full memory: with ADDR_W=5, the 32nd word is written to address 31 and the loader enters DONE; o_word_count=32; no address wrap to 0.
- DONE: o_done=1, o_busy=0, o_byte_ready=0, o_wr_en=0.

Decomposition:
- Shared package: state encoding (IDLE, RECV, WRITE, DONE), HALT_WORD default, BYTES_PER_WORD=4.
- Single module with FSM plus datapath; no sub-module. The byte-assembly shift register is kept inline.

Test Plan:
- Reset: rst=1 for 2 cycles with i_byte_valid=1 -> all outputs 0; no o_wr_en.
- Single word plus halt: start; bytes 12 34 56 78 then FF FF FF FF -> wr_en at addr 0 data 12345678, addr 1 data FFFFFFFF; then o_done=1, o_word_count=2.
- Stalled stream: start; bytes 87,_,65,_,_,43,21 with gaps -> one write at addr 0 data 87654321; o_byte_ready stays 1 through gaps.
- Memory full: start; 32 words 00000000..0000001F -> last write addr 31 data 0000001F; o_done=1, o_word_count=32; 33rd byte not accepted.
- Reset mid-word: after bytes AA BB, assert rst -> IDLE, no write. Restart with DE AD BE EF -> write addr 0 data DEADBEEF.
- Restart after done: i_start in DONE -> o_done=0, o_addr=0, o_word_count=0. i_start pulsed mid-RECV -> ignored; the current load continues uninterrupted.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// State encoding, default HALT encoding and word geometry.
package instr_mem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: byte stream in, big-endian words out.
// Writes consecutive addresses from 0 until HALT or memory full.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_wr_en,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_word_count
);

  localparam logic [1:0] LAST_IDX =
    2'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  state_t     state;
  state_t     state_n;
  logic [1:0] idx;
  logic       accept;
  logic       last;
  logic       stop;
  logic       start_load;

  assign accept = (state == ST_RECV) && i_byte_valid;
  assign last   = (idx == LAST_IDX);
  assign stop   = (o_data == HALT_WORD) || (&o_addr);
  assign start_load = i_start &&
    ((state == ST_IDLE) || (state == ST_DONE));

  assign o_byte_ready = (state == ST_RECV);
  assign o_wr_en      = (state == ST_WRITE);
  assign o_busy       = (state == ST_RECV) ||
                        (state == ST_WRITE);
  assign o_done       = (state == ST_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state: start opens RECV, 4th byte writes, WRITE lasts one cycle.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE,
      ST_DONE: begin
        if (i_start) state_n = ST_RECV;
      end
      ST_RECV: begin
        if (accept && last) state_n = ST_WRITE;
      end
      ST_WRITE: begin
        state_n = stop ? ST_DONE : ST_RECV;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Datapath: byte assembly, address and word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_addr       <= '0;
      o_data       <= '0;
      o_word_count <= '0;
      idx          <= '0;
    end else begin
      if (start_load) begin
        o_addr       <= '0;
        o_word_count <= '0;
        idx          <= '0;
      end
      if (accept) begin
        unique case (idx)
          2'd0: o_data[DATA_W-1 -: 8]  <= i_byte;
          2'd1: o_data[DATA_W-9 -: 8]  <= i_byte;
          2'd2: o_data[DATA_W-17 -: 8] <= i_byte;
          default: o_data[7:0]         <= i_byte;
        endcase
        idx <= last ? 2'd0 : idx + 2'd1;
      end
      if (state == ST_WRITE) begin
        o_word_count <= o_word_count + CNT_ONE;
        if (!stop) o_addr <= o_addr + ADDR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader.
// Vector table, hand sequences and randomized loads vs a word-level model.
module tb_instr_mem_loader;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [7:0]    i_byte;
  logic          i_byte_valid;
  logic          o_byte_ready;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic          o_wr_en;
  logic          o_busy;
  logic          o_done;
  logic [AW:0]   o_word_count;

  instr_mem_loader #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .HALT_WORD(HALT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(i_start),
    .i_byte(i_byte),
    .i_byte_valid(i_byte_valid),
    .o_byte_ready(o_byte_ready),
    .o_addr(o_addr),
    .o_data(o_data),
    .o_wr_en(o_wr_en),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_word_count(o_word_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t wq[$];

  always @(negedge clk)
    if (o_wr_en) wq.push_back({o_addr, o_data});

  typedef struct {
    bit          start;
    logic [31:0] word;
    int          gap;
    logic [AW-1:0] ea;
    logic        edone;
    logic [AW:0] ecnt;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    i_byte = b;
    i_byte_valid = 1'b1;
    while (!o_byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!o_byte_ready)
      chk("byte_ready_timeout", o_byte_ready, 1);
    @(negedge clk);
    i_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w,
                           input int gap);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        i_byte_valid = 1'b0;
        @(negedge clk);
        if (k > 0) chk("ready_in_gap", o_byte_ready, 1);
      end
      send_byte(w[31-8*k -: 8]);
    end
  endtask

  task automatic expect_write(input logic [AW-1:0] a,
                              input logic [31:0] d);
    int n;
    wr_t w;
    n = 0;
    #1;
    while (wq.size() == 0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (wq.size() == 0) begin
      chk("wr_seen", wq.size(), 1);
    end else begin
      w = wq.pop_front();
      chk("wr_addr", w.a, a);
      chk("wr_data", w.d, d);
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] words[$];
    logic [31:0] exp_q[$];
    wr_t w;

    tbl[0] = '{1'b1, 32'h12345678, 0, 5'd0, 1'b0, 6'd1};
    tbl[1] = '{1'b0, 32'hFFFFFFFF, 0, 5'd1, 1'b1, 6'd2};
    tbl[2] = '{1'b1, 32'h87654321, 2, 5'd0, 1'b0, 6'd1};
    tbl[3] = '{1'b0, 32'h0A0B0C0D, 1, 5'd1, 1'b0, 6'd2};

    // Reset with a byte offered.
    rst = 1'b1;
    i_start = 1'b0;
    i_byte = 8'h55;
    i_byte_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_addr", o_addr, 0);
    chk("rst_data", o_data, 0);
    chk("rst_wr_en", o_wr_en, 0);
    chk("rst_ready", o_byte_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_count", o_word_count, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", o_byte_ready, 0);
    chk("idle_data", o_data, 0);
    i_byte_valid = 1'b0;
    chk("rst_no_write", wq.size(), 0);

    // Table-driven words.
    for (int i = 0; i < 4; i++) begin
      if (tbl[i].start) begin
        pulse_start();
        chk("start_done", o_done, 0);
        chk("start_addr", o_addr, 0);
        chk("start_count", o_word_count, 0);
        chk("start_busy", o_busy, 1);
      end
      send_word(tbl[i].word, tbl[i].gap);
      expect_write(tbl[i].ea, tbl[i].word);
      @(negedge clk);
      chk("vec_done", o_done, tbl[i].edone);
      chk("vec_count", o_word_count, tbl[i].ecnt);
    end

    // Start mid-RECV is ignored.
    send_byte(8'h11);
    send_byte(8'h22);
    pulse_start();
    chk("midstart_addr", o_addr, 2);
    chk("midstart_busy", o_busy, 1);
    send_byte(8'h33);
    send_byte(8'h44);
    expect_write(5'd2, 32'h11223344);
    @(negedge clk);
    chk("midstart_count", o_word_count, 3);
    send_word(HALT, 0);
    expect_write(5'd3, HALT);
    @(negedge clk);
    chk("halt_done", o_done, 1);
    chk("halt_count", o_word_count, 4);
    chk("halt_addr_hold", o_addr, 3);

    // Reset mid-word.
    pulse_start();
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", o_busy, 0);
    chk("midrst_data", o_data, 0);
    chk("midrst_addr", o_addr, 0);
    repeat (2) @(negedge clk);
    chk("midrst_no_write", wq.size(), 0);
    pulse_start();
    send_word(32'hDEADBEEF, 0);
    expect_write(5'd0, 32'hDEADBEEF);
    @(negedge clk);
    send_word(HALT, 0);
    expect_write(5'd1, HALT);
    @(negedge clk);

    // Memory full.
    pulse_start();
    for (int i = 0; i < 32; i++) begin
      send_word(32'(i), 0);
      expect_write(5'(i), 32'(i));
    end
    @(negedge clk);
    chk("full_done", o_done, 1);
    chk("full_count", o_word_count, 32);
    chk("full_addr", o_addr, 31);
    i_byte = 8'h99;
    i_byte_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_ready", o_byte_ready, 0);
    end
    i_byte_valid = 1'b0;
    chk("full_data_hold", o_data, 32'h1F);
    chk("full_no_write", wq.size(), 0);

    // Randomized loads vs word-level model.
    for (int ld = 0; ld < 6; ld++) begin
      words.delete();
      exp_q.delete();
      for (int i = 0; i < 40; i++) begin
        if (ld % 3 != 0 && $urandom_range(0, 9) == 0)
          words.push_back(HALT);
        else
          words.push_back($urandom);
      end
      foreach (words[i]) begin
        exp_q.push_back(words[i]);
        if (words[i] == HALT || exp_q.size() == 32)
          break;
      end
      pulse_start();
      foreach (exp_q[i])
        send_word(exp_q[i], $urandom_range(0, 2));
      repeat (3) @(negedge clk);
      #1;
      chk("rnd_nwrites", wq.size(), exp_q.size());
      foreach (exp_q[i]) begin
        if (wq.size() > 0) begin
          w = wq.pop_front();
          chk("rnd_addr", w.a, i);
          chk("rnd_data", w.d, exp_q[i]);
        end
      end
      chk("rnd_done", o_done, 1);
      chk("rnd_count", o_word_count, exp_q.size());
      wq.delete();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
